// File: rtl/adc_serial_capture_if.sv
// rtl/adc_serial_capture_if.sv - sample handshake between ADC capture and filter datapath
// Purpose: carries the captured sample word and its valid/ack/overrun handshake.
// Signals:
//   dato    - CHANNELS*DATA_BITS packed sample, channel c at [c*DATA_BITS +: DATA_BITS]
//   valido  - dato holds an unacknowledged sample
//   overrun - sticky: a frame overwrote an unacknowledged sample
//   ack     - consumer accepts current dato
// Modports: master = capture block (drives sample), slave = consumer (drives ack).
interface adc_serial_capture_if #(
    parameter int CHANNELS  = 2,
    parameter int DATA_BITS = 12
);
    logic [CHANNELS*DATA_BITS-1:0] dato;
    logic                          valido;
    logic                          overrun;
    logic                          ack;

    modport master (output dato, output valido, output overrun, input ack);
    modport slave  (input dato, input valido, input overrun, output ack);
endinterface

// File: rtl/adc_serial_capture.sv
// rtl/adc_serial_capture.sv - serial ADC frame receiver with valid/ack/overrun
// Purpose: drives ADC chip select, shifts CHANNELS MSB-first serial lines for
// FRAME_BITS clocks, keeps the low DATA_BITS of each channel and presents them
// as a packed word with a valid/ack handshake and sticky overrun flag.
// Ports:
//   clock44kHz - sample/serial clock, rising edge
//   reset      - asynchronous, active-high
//   datoADC    - serial data, bit c = channel c
//   inicio     - single conversion request
//   continuo   - back-to-back frames while high
//   CS_out     - ADC chip select, active low, registered
//   ocupado    - high whenever the receiver is not idle
//   cap        - sample handshake (dato/valido/overrun out, ack in)
module adc_serial_capture #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int CHANNELS   = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clock44kHz,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   datoADC,
    input  logic                  inicio,
    input  logic                  continuo,
    output logic                  CS_out,
    output logic                  ocupado,
    adc_serial_capture_if.master  cap
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE,
        S_GAP
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [CW-1:0]                  r_bit_cnt;
    logic [GW-1:0]                  r_gap_cnt;
    logic                           r_cs;
    logic                           r_ocupado;
    // Only the low DATA_BITS of each frame are kept: the leading bits of the
    // frame fall off the top of this register while shifting.
    logic [DATA_BITS-1:0]           r_shreg [CHANNELS];
    logic [CHANNELS*DATA_BITS-1:0]  r_dato;
    logic                           r_valido;
    logic                           r_overrun;
    logic                           w_start;

    // continuo has priority over inicio, but both lead to the same next frame
    assign w_start = inicio | continuo;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_bit_cnt == CW'(FRAME_BITS - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_GAP;
            S_GAP:   if (r_gap_cnt == GW'(GAP_CYCLES - 1))
                         w_state_nxt = w_start ? S_SHIFT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control: CS and ocupado are registered from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clock44kHz or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cs      <= 1'b1;
            r_ocupado <= 1'b0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cs      <= (w_state_nxt != S_SHIFT);
            r_ocupado <= (w_state_nxt != S_IDLE);
            r_bit_cnt <= (r_state == S_SHIFT) ? r_bit_cnt + CW'(1) : '0;
            r_gap_cnt <= (r_state == S_GAP)   ? r_gap_cnt + GW'(1) : '0;
        end
    end

    // Datapath and handshake
    always_ff @(posedge clock44kHz or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) r_shreg[c] <= '0;
            r_dato    <= '0;
            r_valido  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == S_SHIFT) begin
                for (int c = 0; c < CHANNELS; c++)
                    r_shreg[c] <= DATA_BITS'({r_shreg[c], datoADC[c]});
            end
            if (r_state == S_DONE) begin
                // a new sample always wins over a coincident ack
                for (int c = 0; c < CHANNELS; c++)
                    r_dato[c*DATA_BITS +: DATA_BITS] <= r_shreg[c];
                r_valido <= 1'b1;
                if (r_valido && !cap.ack)
                    r_overrun <= 1'b1;
                else if (cap.ack)
                    r_overrun <= 1'b0;
            end else if (cap.ack) begin
                r_valido  <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign CS_out      = r_cs;
    assign ocupado     = r_ocupado;
    assign cap.dato    = r_dato;
    assign cap.valido  = r_valido;
    assign cap.overrun = r_overrun;
endmodule
